// File: rtl/seq_detect_param.sv
// Serial pattern detector: matches a programmable PAT_LEN-bit word on a 1-bit stream,
// with overlapping/non-overlapping modes, sample enable and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned PAT_LEN = 3,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FILL_W  = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               seq_in_i,
    input  logic [PAT_LEN-1:0] pattern_i,
    input  logic               overlap_i,
    input  logic               clear_i,
    output logic               seq_detected_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic [FILL_W-1:0]  fill_out_o
);

    localparam logic [FILL_W-1:0] FillMax = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FillArm = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, det_d;

    logic [PAT_LEN-1:0] cand;
    logic               hit;

    // The arm check keeps stale history (after reset, clear or a non-overlap hit) from matching.
    assign cand = {hist_q[PAT_LEN-2:0], seq_in_i};
    assign hit  = (cand == pattern_i) && (fill_q >= FillArm);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        det_d  = 1'b0;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en_i) begin
            hist_d = cand;
            det_d  = hit;
            if (hit && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (hit && !overlap_i) begin
                fill_d = '0;
            end else if (fill_q != FillMax) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            det_q  <= det_d;
        end
    end

    assign seq_detected_o = det_q;
    assign match_count_o  = cnt_q;
    assign fill_out_o     = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven by a shared stream and checked
// against a reference model built on a running bit word and a count of bits since flush.
module tb_seq_detect_param;

    logic clk;
    logic reset;
    logic en;
    logic seq_in;
    logic overlap;
    logic clear;
    logic [2:0] pat3;
    logic [3:0] pat4;
    logic [2:0] patc;

    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [1:0] fill0, fill2;
    logic [2:0] fill1;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    // Reference model state per instance
    longint unsigned rec[3];
    int              nbits[3];
    int              mcnt[3];
    bit              mdet[3];
    int              plen[3] = '{3, 4, 3};
    int              cmax[3] = '{255, 255, 3};

    seq_detect_param #(.PAT_LEN(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .reset(reset), .en_i(en), .seq_in_i(seq_in), .pattern_i(pat3),
        .overlap_i(overlap), .clear_i(clear), .seq_detected_o(det0), .match_count_o(cnt0),
        .fill_out_o(fill0)
    );

    seq_detect_param #(.PAT_LEN(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .en_i(en), .seq_in_i(seq_in), .pattern_i(pat4),
        .overlap_i(overlap), .clear_i(clear), .seq_detected_o(det1), .match_count_o(cnt1),
        .fill_out_o(fill1)
    );

    seq_detect_param #(.PAT_LEN(3), .CNT_W(2)) u_dutc (
        .clk(clk), .reset(reset), .en_i(en), .seq_in_i(seq_in), .pattern_i(patc),
        .overlap_i(overlap), .clear_i(clear), .seq_detected_o(det2), .match_count_o(cnt2),
        .fill_out_o(fill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned pat_of(int i);
        if (i == 0) return longint'(pat3);
        if (i == 1) return longint'(pat4);
        return longint'(patc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            rec[i] = 0; nbits[i] = 0; mcnt[i] = 0; mdet[i] = 1'b0;
        end
    endtask

    // One sampling edge: a match needs PAT_LEN bits since the last flush, and the newest
    // PAT_LEN of them equal to the pattern.
    task automatic model_clock();
        longint unsigned mask;
        bit hit;
        for (int i = 0; i < 3; i++) begin
            mask = (64'd1 << plen[i]) - 64'd1;
            if (clear) begin
                nbits[i] = 0; mcnt[i] = 0; mdet[i] = 1'b0;
            end else if (en) begin
                rec[i] = (rec[i] << 1) | longint'(seq_in);
                nbits[i]++;
                hit = (nbits[i] >= plen[i]) && ((rec[i] & mask) == pat_of(i));
                mdet[i] = hit;
                if (hit && mcnt[i] < cmax[i]) mcnt[i]++;
                if (hit && !overlap) nbits[i] = 0;
            end else begin
                mdet[i] = 1'b0;
            end
        end
    endtask

    function automatic int exp_fill(int i);
        return (nbits[i] < plen[i]) ? nbits[i] : plen[i];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".det0"}, 32'(det0), 32'(mdet[0]));
        chk({tag, ".det1"}, 32'(det1), 32'(mdet[1]));
        chk({tag, ".det2"}, 32'(det2), 32'(mdet[2]));
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(mcnt[0]));
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(mcnt[1]));
        chk({tag, ".cnt2"}, 32'(cnt2), 32'(mcnt[2]));
        chk({tag, ".fill0"}, 32'(fill0), 32'(exp_fill(0)));
        chk({tag, ".fill1"}, 32'(fill1), 32'(exp_fill(1)));
        chk({tag, ".fill2"}, 32'(fill2), 32'(exp_fill(2)));
    endtask

    task automatic step(input string tag, input logic e, input logic b, input logic c);
        @(negedge clk);
        en = e; seq_in = b; clear = c;
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic bits(input string tag, input int n, input logic [31:0] v);
        for (int k = n - 1; k >= 0; k--) step(tag, 1'b1, v[k], 1'b0);
    endtask

    task automatic areset(input string tag);
        @(negedge clk);
        en = 1'b0; clear = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1 check_all(tag);
        #1 reset = 1'b1;
        @(posedge clk);
        model_clock();
        #1 check_all({tag, ".post"});
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; seq_in = 1'b0; clear = 1'b0; overlap = 1'b1;
        pat3 = 3'b101; pat4 = 4'b1111; patc = 3'b111;
        model_reset();
        #3 reset = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // 1,0,1,0,1 overlapping then non-overlapping
        bits("ovl", 5, 32'b10101);
        chk("ovl.count", 32'(cnt0), 32'd2);
        step("clr1", 1'b1, 1'b0, 1'b1);
        overlap = 1'b0;
        bits("novl", 5, 32'b10101);
        chk("novl.count", 32'(cnt0), 32'd1);
        chk("novl.fill", 32'(fill0), 32'd2);

        // seven 1s on the 4-bit detector, both modes
        step("clr2", 1'b1, 1'b0, 1'b1);
        overlap = 1'b1;
        bits("ones_ovl", 7, 32'h7f);
        chk("ones_ovl.count4", 32'(cnt1), 32'd4);
        step("clr3", 1'b1, 1'b0, 1'b1);
        overlap = 1'b0;
        bits("ones_novl", 7, 32'h7f);
        chk("ones_novl.count4", 32'(cnt1), 32'd1);
        chk("ones_novl.fill4", 32'(fill1), 32'd3);

        // enable gap in the middle of a match
        step("clr4", 1'b1, 1'b0, 1'b1);
        bits("gap_pre", 2, 32'b10);
        for (int k = 0; k < 3; k++) step("gap_idle", 1'b0, 1'b1, 1'b0);
        step("gap_post", 1'b1, 1'b1, 1'b0);
        chk("gap.det", 32'(det0), 32'd1);

        // counter saturation at CNT_W=2
        step("clr5", 1'b1, 1'b0, 1'b1);
        overlap = 1'b1;
        bits("sat", 8, 32'hff);
        chk("sat.count", 32'(cnt2), 32'd3);

        // async reset mid-stream, then clear with en=1
        step("clr6", 1'b1, 1'b0, 1'b1);
        bits("rst_pre", 2, 32'b10);
        areset("mid_rst");
        step("rst_bit", 1'b1, 1'b1, 1'b0);
        chk("rst.fill", 32'(fill0), 32'd1);
        chk("rst.det", 32'(det0), 32'd0);
        bits("clr_pre", 2, 32'b10);
        step("clr_en", 1'b1, 1'b1, 1'b1);
        chk("clr_en.fill", 32'(fill0), 32'd0);
        chk("clr_en.count", 32'(cnt0), 32'd0);

        // randomized traffic with live pattern/mode changes
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                pat3 = 3'($urandom_range(0, 7));
                pat4 = 4'($urandom_range(0, 15));
                patc = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 19) == 0) overlap = ~overlap;
            if ($urandom_range(0, 149) == 0) areset("rnd_rst");
            step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
